// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and sequencer state type for the instruction sequencer
package cpu_pkg;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int MAX_MACHINE_CODE_LENGTH = 64;
  localparam int ADDRESS_WIDTH = $clog2(MAX_MACHINE_CODE_LENGTH);
  localparam logic [INSTRUCTION_WIDTH-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sequencer_state_t;
endpackage

// File: rtl/instruction_memory.sv
// instruction_memory: program store with one synchronous write port and one combinational read port
module instruction_memory
  import cpu_pkg::*;
(
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDRESS_WIDTH-1:0]     wr_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] wr_data,
  input  logic [ADDRESS_WIDTH-1:0]     rd_addr,
  output logic [INSTRUCTION_WIDTH-1:0] rd_data
);
  logic [INSTRUCTION_WIDTH-1:0] mem [MAX_MACHINE_CODE_LENGTH];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: issues stored program words to the cpu over a valid/ready handshake
module instruction_sequencer
  import cpu_pkg::*;
(
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         load_enable_in,
  input  logic [ADDRESS_WIDTH-1:0]     load_address_in,
  input  logic [INSTRUCTION_WIDTH-1:0] load_data_in,
  input  logic                         start_in,
  input  logic [ADDRESS_WIDTH:0]       program_length_in,
  input  logic                         abort_in,
  input  logic                         cpu_ready_in,
  output logic [INSTRUCTION_WIDTH-1:0] current_instruction,
  output logic                         instruction_valid_out,
  output logic [ADDRESS_WIDTH-1:0]     program_counter_out,
  output logic                         busy_out,
  output logic                         done_out
);
  sequencer_state_t state, state_n;
  logic [ADDRESS_WIDTH-1:0] pc_n, rd_addr;
  logic [INSTRUCTION_WIDTH-1:0] instr_n, rd_data;
  logic valid_n, last;
  logic [ADDRESS_WIDTH:0] len, len_n;
  // Read port looks one word ahead while running so the next word is ready on each handshake
  assign rd_addr = state == RUN ? program_counter_out + 1'b1 : '0;
  assign last = {1'b0, program_counter_out} == len - 1'b1 || current_instruction == HALT_INSTRUCTION;
  assign busy_out = state == RUN;
  assign done_out = state == DONE;
  instruction_memory u_mem (
    .clk    (clock_in),
    .we     (load_enable_in && state != RUN),
    .wr_addr(load_address_in),
    .wr_data(load_data_in),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
  always_comb begin
    state_n = state;
    pc_n = program_counter_out;
    instr_n = current_instruction;
    valid_n = instruction_valid_out;
    len_n = len;
    case (state)
      IDLE: if (start_in && program_length_in != '0) begin
        state_n = RUN;
        pc_n = '0;
        instr_n = rd_data;
        valid_n = 1'b1;
        len_n = program_length_in > 7'd64 ? 7'd64 : program_length_in;
      end
      RUN: if (abort_in) begin
        state_n = IDLE;
        valid_n = 1'b0;
        instr_n = '0;
      end else if (instruction_valid_out && cpu_ready_in) begin
        state_n = last ? DONE : RUN;
        valid_n = !last;
        instr_n = last ? '0 : rd_data;
        pc_n = last ? program_counter_out : program_counter_out + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock_in)
    if (reset_in) begin
      state <= IDLE;
      program_counter_out <= '0;
      current_instruction <= '0;
      instruction_valid_out <= 1'b0;
      len <= '0;
    end else begin
      state <= state_n;
      program_counter_out <= pc_n;
      current_instruction <= instr_n;
      instruction_valid_out <= valid_n;
      len <= len_n;
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed self-checking bench for instruction_sequencer
module tb_instruction_sequencer;
  logic clock_in = 1'b0;
  logic reset_in, load_enable_in, start_in, abort_in, cpu_ready_in;
  logic [5:0] load_address_in;
  logic [31:0] load_data_in;
  logic [6:0] program_length_in;
  logic [31:0] current_instruction;
  logic instruction_valid_out, busy_out, done_out;
  logic [5:0] program_counter_out;
  logic [31:0] model [64];
  int vectors = 0;
  int miscompares = 0;

  instruction_sequencer dut (
    .clock_in(clock_in), .reset_in(reset_in), .load_enable_in(load_enable_in),
    .load_address_in(load_address_in), .load_data_in(load_data_in), .start_in(start_in),
    .program_length_in(program_length_in), .abort_in(abort_in), .cpu_ready_in(cpu_ready_in),
    .current_instruction(current_instruction), .instruction_valid_out(instruction_valid_out),
    .program_counter_out(program_counter_out), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [31:0] d);
    load_enable_in = 1'b1;
    load_address_in = 6'(a);
    load_data_in = d;
    step();
    load_enable_in = 1'b0;
    model[a] = d;
  endtask

  // mode 0: ready always high; mode 1: ready 1,0,0 with start held high; mode 2: ready high with load attempts
  task automatic run(input int len, input int mode, input int exp_n);
    int k = 0;
    int cyc = 0;
    bit held = 0;
    bit done_seen = 0;
    logic [31:0] held_instr = '0;
    start_in = 1'b1;
    program_length_in = 7'(len);
    step();
    start_in = 1'b0;
    chk("first_valid", instruction_valid_out, 1);
    while (cyc < 300) begin
      if (done_out) begin
        done_seen = 1;
        break;
      end
      if (!busy_out) break;
      if (held) chk("hold_stable", current_instruction, held_instr);
      cpu_ready_in = mode == 1 ? (cyc % 3 == 0) : 1'b1;
      start_in = mode == 1;
      program_length_in = mode == 1 ? 7'd2 : program_length_in;
      load_enable_in = mode == 2;
      load_address_in = 6'd1;
      load_data_in = 32'hDEAD_BEEF;
      if (instruction_valid_out && cpu_ready_in) begin
        chk("word", current_instruction, model[k]);
        chk("pc", {26'd0, program_counter_out}, k);
        k++;
        held = 0;
      end else begin
        held = instruction_valid_out;
        held_instr = current_instruction;
      end
      step();
      cyc++;
    end
    start_in = 1'b0;
    load_enable_in = 1'b0;
    chk("issue_count", k, exp_n);
    chk("done_seen", done_seen, 1);
    chk("valid_in_done", instruction_valid_out, 0);
    step();
    chk("done_one_cycle", done_out, 0);
    chk("busy_after", busy_out, 0);
  endtask

  initial begin
    reset_in = 1'b1;
    load_enable_in = 1'b0;
    load_address_in = '0;
    load_data_in = '0;
    start_in = 1'b0;
    program_length_in = '0;
    abort_in = 1'b0;
    cpu_ready_in = 1'b0;
    step();
    step();
    chk("rst_instr", current_instruction, 0);
    chk("rst_valid", instruction_valid_out, 0);
    chk("rst_pc", {26'd0, program_counter_out}, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    reset_in = 1'b0;
    for (int i = 0; i < 4; i++) load(i, 32'h11 * (i + 1));
    // full-rate run
    run(4, 0, 4);
    // stalling ready with start held high during RUN
    run(4, 1, 4);
    // HALT word ends the program after being issued
    load(2, 32'hFFFF_FFFF);
    run(4, 0, 3);
    load(2, 32'h33);
    // zero length start is ignored
    start_in = 1'b1;
    program_length_in = 7'd0;
    step();
    start_in = 1'b0;
    chk("len0_busy", busy_out, 0);
    chk("len0_valid", instruction_valid_out, 0);
    // oversize length clamps to the full store
    for (int i = 0; i < 64; i++) load(i, 32'h100 + 3 * i);
    run(100, 0, 64);
    chk("clamp_last_pc", {26'd0, program_counter_out}, 63);
    for (int i = 0; i < 4; i++) load(i, 32'h11 * (i + 1));
    // abort after second word accepted
    cpu_ready_in = 1'b1;
    start_in = 1'b1;
    program_length_in = 7'd4;
    step();
    start_in = 1'b0;
    step();
    step();
    chk("pre_abort_word", current_instruction, 32'h33);
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    chk("abort_valid", instruction_valid_out, 0);
    chk("abort_instr", current_instruction, 0);
    chk("abort_busy", busy_out, 0);
    chk("abort_done", done_out, 0);
    step();
    chk("abort_no_done", done_out, 0);
    run(4, 0, 4);
    // reset after second word accepted
    start_in = 1'b1;
    program_length_in = 7'd4;
    step();
    start_in = 1'b0;
    step();
    step();
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    chk("reset_valid", instruction_valid_out, 0);
    chk("reset_pc", {26'd0, program_counter_out}, 0);
    chk("reset_busy", busy_out, 0);
    chk("reset_done", done_out, 0);
    run(4, 0, 4);
    // load attempts during RUN must not alter the store
    run(4, 2, 4);
    run(4, 0, 4);
    // load and start on the same edge issue the old word 0
    load_enable_in = 1'b1;
    load_address_in = 6'd0;
    load_data_in = 32'h99;
    start_in = 1'b1;
    program_length_in = 7'd1;
    step();
    load_enable_in = 1'b0;
    start_in = 1'b0;
    chk("same_edge_old", current_instruction, 32'h11);
    step();
    chk("same_edge_done", done_out, 1);
    step();
    model[0] = 32'h99;
    run(1, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
